// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encodings match the MD_* constants used by the execute stage.
package mult_div_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITER  = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_CALC = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> multiply/divide unit request/response bundle.
// The execute stage is the master; the unit is the slave.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = mult_div_unit_pkg::MD_WIDTH
);
    import mult_div_unit_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation of a {hi,lo} pair: either each half
// independently, or the whole double-width value as one number (i_wide).
module md_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [2*W-1:0] i_val,
    input  logic           i_wide,
    input  logic           i_neg_hi,
    input  logic           i_neg_lo,
    output logic [2*W-1:0] o_val
);

    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;

    always_comb begin
        w_hi = i_neg_hi ? -i_val[2*W-1:W] : i_val[2*W-1:W];
        w_lo = i_neg_lo ? -i_val[W-1:0]   : i_val[W-1:0];
        if (i_wide) begin
            o_val = i_neg_hi ? -i_val : i_val;
        end else begin
            o_val = {w_hi, w_lo};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Fixed-latency radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU).
// Operates on magnitudes and applies signs in a single fix-up cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITER  = MD_ITER
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam int unsigned     CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic               w_accept;
    logic               w_busy;

    logic [CNT_W-1:0]   r_cnt;
    md_op_e             r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_res_neg;
    logic               r_rem_neg;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_is_div;
    logic               w_signed;
    logic [2*WIDTH-1:0] w_abs;
    logic [2*WIDTH-1:0] w_fix_in;
    logic [2*WIDTH-1:0] w_fix;
    logic [WIDTH:0]     w_add;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;

    assign w_is_div = md_is_div(r_op);
    assign w_signed = md_is_signed(r_op);

    // Operand magnitudes for PREP
    md_sign_fix #(.W(WIDTH)) u_abs (
        .i_val    ({r_a, r_b}),
        .i_wide   (1'b0),
        .i_neg_hi (w_signed & r_a[WIDTH-1]),
        .i_neg_lo (w_signed & r_b[WIDTH-1]),
        .o_val    (w_abs)
    );

    // Result sign restoration for FIX: whole product, or quotient/remainder separately
    assign w_fix_in = w_is_div ? {r_rem[WIDTH-1:0], r_quo} : r_acc;

    md_sign_fix #(.W(WIDTH)) u_fix (
        .i_val    (w_fix_in),
        .i_wide   (~w_is_div),
        .i_neg_hi (w_is_div ? r_rem_neg : r_res_neg),
        .i_neg_lo (r_res_neg),
        .o_val    (w_fix)
    );

    // Shift-add step; restoring-divide step (sign of trial difference decides the quotient bit)
    assign w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_mag_b};
    assign w_ge    = ~w_diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            MD_IDLE, MD_DONE: begin
                w_state_nxt = MD_IDLE;
                if (md.start) begin
                    w_accept    = 1'b1;
                    w_busy      = 1'b1;
                    w_state_nxt = MD_PREP;
                end
            end
            MD_PREP: begin
                w_busy      = 1'b1;
                w_state_nxt = MD_CALC;
            end
            MD_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = MD_FIX;
                end
            end
            MD_FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = MD_DONE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_op      <= MD_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= md.op;
                r_a  <= md.a;
                r_b  <= md.b;
            end
            case (r_state)
                MD_PREP: begin
                    r_mag_a   <= w_abs[2*WIDTH-1:WIDTH];
                    r_mag_b   <= w_abs[WIDTH-1:0];
                    r_acc     <= {{WIDTH{1'b0}}, w_abs[WIDTH-1:0]};
                    r_rem     <= '0;
                    r_quo     <= w_abs[2*WIDTH-1:WIDTH];
                    r_res_neg <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_rem_neg <= w_signed & r_a[WIDTH-1];
                    r_div0    <= w_is_div && (r_b == '0);
                    r_cnt     <= '0;
                end
                MD_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_is_div) begin
                        r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= {w_add, r_acc[WIDTH-1:1]};
                    end
                end
                MD_FIX: begin
                    // Divide-by-zero: all-ones quotient, dividend passed through as remainder
                    if (r_div0) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
            r_done <= (r_state == MD_FIX);
        end
    end

    assign md.busy = w_busy;
    assign md.done = r_done;
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;

endmodule
